ov9281_frame_ctrl: RTL
======================

// Module: ov9281_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the OV9281 DVP capture path, camera_pclk domain.
//  Arms capture after sensor init, aligns to frame boundaries and gates the 32-bit word writes
//  from the capture stage into the DDR write FIFO. Checks line/frame geometry, drops frames on
//  FIFO overflow risk, and issues burst requests to the DDR write scheduler.
// PARAMETERS
//  H_BYTES    1280  valid bytes per line (href high); must be a multiple of 4
//  V_LINES    800   lines per frame
//  BURST_LEN  64    32-bit words per DDR write burst request
//  CNT_W      12    width of line/byte counters
// PORTS
//  camera_pclk   in   1      pixel clock
//  rst_n         in   1      async active-low reset
//  init_done     in   1      sensor register init complete (level)
//  capture_en    in   1      software capture enable (level, pclk-synchronous)
//  camera_vsync  in   1      frame sync, high = blanking
//  camera_href   in   1      line valid
//  word_valid    in   1      capture stage has a packed 32-bit word this cycle
//  fifo_afull    in   1      DDR write FIFO almost-full
//  wr_gate       out  1      qualifies word_valid into FIFO write enable
//  frame_start   out  1      1-cycle pulse at the accepted frame's first active cycle
//  frame_done    out  1      1-cycle pulse after the last word of a good frame
//  frame_err     out  1      1-cycle pulse: geometry mismatch or dropped frame
//  burst_req     out  1      level; burst of burst_words ready in FIFO
//  burst_words   out  8      words in requested burst (BURST_LEN, or remainder on flush)
//  burst_ack     in   1      scheduler accepted the current request
//  line_cnt      out  CNT_W  lines completed in the current frame
//  frame_cnt     out  16     good frames completed, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  vs_fall = vsync high previous cycle, low this cycle (one register stage); likewise href_fall.
//  FSM:
//   IDLE    -> ARM when init_done && capture_en.
//   ARM     -> wait for vsync high (never start mid-frame); -> SYNC.
//   SYNC    -> on vs_fall: ACTIVE; frame_start pulses the same cycle.
//   ACTIVE  -> wr_gate = 1; byte_cnt += 1 per href cycle, cleared on href_fall;
//              line_cnt += 1 on href_fall (byte_cnt != H_BYTES -> geom error latched).
//              On fifo_afull && word_valid -> DROP. On vsync rise -> FLUSH.
//   DROP    -> wr_gate = 0; frame_err pulses on entry; on vsync rise -> ARM (pending words
//              still flushed); frame_cnt unchanged.
//   FLUSH   -> issue remainder burst if pending > 0; after its ack: frame_done
//              (line_cnt == V_LINES, no geom error) else frame_err; -> ARM or IDLE.
//  capture_en low: frame in progress completes; state returns to IDLE instead of ARM.
//  Burst accounting: pending += 1 per gated word; burst_req rises when pending >= BURST_LEN
//   (burst_words = BURST_LEN), held until burst_ack; pending -= burst_words on ack.
//   Simultaneous word and ack: both applied the same cycle. Flush request uses
//   burst_words = pending.
//  Latency: wr_gate combinational from state (no added latency); pulses 1 cycle after the event.
//  Async reset mid-frame: abort immediately; the next capture waits for a full vsync cycle.
// CONFIGURATION
//  OV9281_FRAME_DECIM_EN defined: adds input decim[3:0]; only every (decim+1)-th frame is
//   captured, skipped frames stay in SYNC with wr_gate = 0 and no pulses.
//  Not defined: every frame captured; no decim port.
// STRUCTURE
//  Package ov9281_pkg: FSM state enum, H_BYTES/V_LINES defaults, BURST_LEN, error codes.
//  Sub-module ov9281_burst_acct (pending counter + req/ack handshake) instantiated once;
//   FSM and geometry counters stay in this module.
// TESTING
//  1. init_done=1, capture_en=1, 2 frames 1280x800 -> frame_start x2, frame_done x2, frame_cnt=2,
//     burst_req count = 2*256000/64 = 8000, no frame_err.
//  2. Enable mid-frame (vsync low) -> no wr_gate until after the next vsync high->low.
//  3. fifo_afull asserted at line 100 -> frame_err pulse, wr_gate=0 rest of frame, frame_cnt
//     unchanged, next frame good.
//  4. Line of 1276 bytes -> frame_err at FLUSH, no frame_done.
//  5. BURST_LEN=64, frame of 100 words -> one burst of 64, flush burst_words=36; word and ack
//     in the same cycle keep pending exact.
//  6. With OV9281_FRAME_DECIM_EN, decim=2 over 6 frames -> exactly 2 frame_done.

Source files
------------

// File: rtl/ov9281_pkg.sv
// Shared types and defaults for the OV9281 frame sequencer.
// The sequencer FSM states and the frame error classification live here.
package ov9281_pkg;
  localparam int H_BYTES_DEF   = 1280;
  localparam int V_LINES_DEF   = 800;
  localparam int BURST_LEN_DEF = 64;
  localparam int CNT_W_DEF     = 12;
  localparam int PEND_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_SYNC, ST_ACTIVE, ST_DROP, ST_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_GEOM, ERR_DROP
  } err_e;
endpackage

// File: rtl/ov9281_burst_acct.sv
// Pending-word accounting and burst request/ack handshake toward the DDR write scheduler.
// Full bursts go out as soon as enough words are pending; flush drains the remainder.
module ov9281_burst_acct import ov9281_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic       camera_pclk,
  input  logic       rst_n,
  input  logic       word_inc,
  input  logic       flush,
  input  logic       burst_ack,
  output logic       burst_req,
  output logic [7:0] burst_words,
  output logic       flush_done
);
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              req_q, req_d;
  logic [7:0]        words_q, words_d;

  always_comb begin
    pending_d = pending_q + PEND_W'(word_inc);
    if (req_q && burst_ack) pending_d = pending_d - PEND_W'(words_q);
    req_d   = req_q;
    words_d = words_q;
    // A new request may be raised in the same cycle the previous one is acked.
    if (!req_q || burst_ack) begin
      req_d   = 1'b0;
      words_d = '0;
      if (pending_d >= PEND_W'(BURST_LEN)) begin
        req_d   = 1'b1;
        words_d = 8'(BURST_LEN);
      end else if (flush && pending_d != '0) begin
        req_d   = 1'b1;
        words_d = pending_d[7:0];
      end
    end
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      req_q     <= 1'b0;
      words_q   <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req_d;
      words_q   <= words_d;
    end
  end

  assign burst_req   = req_q;
  assign burst_words = words_q;
  assign flush_done  = flush && !req_q && (pending_q == '0);
endmodule

// File: rtl/ov9281_frame_ctrl.sv
// OV9281 DVP frame sequencer: arms on init, aligns to vsync, gates capture words and checks geometry.
// Optional OV9281_FRAME_DECIM_EN adds a decim[3:0] input capturing every (decim+1)-th frame.
module ov9281_frame_ctrl import ov9281_pkg::*; #(
  parameter int H_BYTES   = H_BYTES_DEF,
  parameter int V_LINES   = V_LINES_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             camera_pclk,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic             capture_en,
  input  logic             camera_vsync,
  input  logic             camera_href,
  input  logic             word_valid,
  input  logic             fifo_afull,
  output logic             wr_gate,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic             burst_req,
  output logic [7:0]       burst_words,
  input  logic             burst_ack,
`ifdef OV9281_FRAME_DECIM_EN
  input  logic [3:0]       decim,
`endif
  output logic [CNT_W-1:0] line_cnt,
  output logic [15:0]      frame_cnt
);
  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic             vsync_q, href_q;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             vs_fall, vs_rise, href_fall, take_frame, flush_done;

  assign vs_fall   = vsync_q && !camera_vsync;
  assign vs_rise   = !vsync_q && camera_vsync;
  assign href_fall = href_q && !camera_href;
  assign wr_gate   = (state_q == ST_ACTIVE);

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    byte_cnt_d    = byte_cnt_q;
    line_cnt_d    = line_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (init_done && capture_en) state_d = ST_ARM;
      // Waiting for vsync high first guarantees we never start mid-frame.
      ST_ARM: begin
        if (!capture_en)       state_d = ST_IDLE;
        else if (camera_vsync) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!capture_en) state_d = ST_IDLE;
        else if (vs_fall && take_frame) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          err_d         = ERR_NONE;
          byte_cnt_d    = '0;
          line_cnt_d    = '0;
        end
      end
      ST_ACTIVE: begin
        if (camera_href) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (href_fall) begin
          byte_cnt_d = '0;
          line_cnt_d = line_cnt_q + CNT_W'(1);
          if (byte_cnt_q != CNT_W'(H_BYTES)) err_d = ERR_GEOM;
        end
        if (fifo_afull && word_valid) begin
          state_d     = ST_DROP;
          err_d       = ERR_DROP;
          frame_err_d = 1'b1;
        end else if (vs_rise) begin
          state_d = ST_FLUSH;
        end
      end
      ST_DROP: if (vs_rise) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (flush_done) begin
          state_d = capture_en ? ST_ARM : ST_IDLE;
          // A dropped frame already reported its error on entry to DROP.
          if (err_q == ERR_NONE && line_cnt_q == CNT_W'(V_LINES)) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else if (err_q != ERR_DROP) begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef OV9281_FRAME_DECIM_EN
  logic [3:0] decim_cnt_q, decim_cnt_d;
  assign take_frame = (decim_cnt_q == decim);

  always_comb begin
    decim_cnt_d = decim_cnt_q;
    if (state_q == ST_IDLE) decim_cnt_d = '0;
    else if (state_q == ST_SYNC && vs_fall) decim_cnt_d = take_frame ? 4'd0 : decim_cnt_q + 4'd1;
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) decim_cnt_q <= '0;
    else        decim_cnt_q <= decim_cnt_d;
  end
`else
  assign take_frame = 1'b1;
`endif

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      err_q         <= ERR_NONE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      vsync_q       <= camera_vsync;
      href_q        <= camera_href;
      byte_cnt_q    <= byte_cnt_d;
      line_cnt_q    <= line_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  ov9281_burst_acct #(.BURST_LEN(BURST_LEN)) u_burst (
    .camera_pclk (camera_pclk),
    .rst_n       (rst_n),
    .word_inc    (wr_gate && word_valid),
    .flush       (state_q == ST_FLUSH),
    .burst_ack   (burst_ack),
    .burst_req   (burst_req),
    .burst_words (burst_words),
    .flush_done  (flush_done)
  );

  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign line_cnt    = line_cnt_q;
  assign frame_cnt   = frame_cnt_q;
endmodule
